mips_cpu_wb_arbiter: RTL and testbench
======================================

MIPS_CPU_WB_ARBITER -- requirements
Module: mips_cpu_wb_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 3, SHALL be the number of consecutive requester-0 grants tolerated while requester 1 waits; legal range 1..7.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low (asserted at 0); SHALL clear all state immediately, independent of clk.
REQ-004 req0_valid  input  1  requester 0 (ALU writeback) has a write pending.
REQ-005 req0_index  input  5  requester 0 destination register.
REQ-006 req0_data  input  32  requester 0 write value.
REQ-007 req0_ready  output  1  requester 0 granted this cycle.
REQ-008 req1_valid / req1_index / req1_data / req1_ready  in/in/in/out  1/5/32/1  requester 1 (load writeback), same meanings.
REQ-009 write_enable  output  1  registered write strobe to the register-file write port.
REQ-010 write_index  output  5  registered write port index.
REQ-011 write_data  output  32  registered write port data.
REQ-012 hazard_index_a, hazard_index_b  input  5  read-port indices to check (rs, rt).
REQ-013 hazard_a, hazard_b  output  1  a write to that index is accepted but not yet committed.
REQ-014 force1  output  1  state flag: FAIR state active.

Function
REQ-015 A transfer SHALL occur on a rising edge where reqN_valid=1 and reqN_ready=1; requesters SHALL hold valid, index and data stable until that edge.
REQ-016 reqN_ready SHALL be combinational and SHALL never be 1 while reqN_valid=0; at most one ready SHALL be 1 per cycle.
REQ-017 State NORMAL: req0 has priority; req1_ready = req1_valid & ~req0_valid.
REQ-018 State FAIR: req1 has priority; req0_ready = req0_valid & ~req1_valid.
REQ-019 3-bit starve counter: +1 on each req0 transfer while req1_valid=1; cleared on any req1 transfer or any cycle with req1_valid=0; SHALL never exceed STARVE_LIMIT.
REQ-020 NORMAL -> FAIR when counter reaches STARVE_LIMIT; FAIR -> NORMAL after the next req1 transfer, or when req1_valid=0.
REQ-021 On a transfer at edge N, write_index/write_data SHALL take the granted values and write_enable SHALL be 1 for exactly cycle N..N+1 (one cycle latency, one-cycle strobe).
REQ-022 Transfer with index 0 SHALL be accepted (ready=1) but SHALL produce write_enable=0.
REQ-023 With no transfer, write_enable SHALL be 0 next cycle; write_index/write_data SHALL hold.
REQ-024 Throughput SHALL be one transfer per cycle, back-to-back, no bubbles; no internal buffering beyond the output register.
REQ-025 hazard_x SHALL be 1 when hazard_index_x!=0 and it equals write_index with write_enable=1, or equals the index of a transfer occurring in the current cycle; otherwise 0.
REQ-026 Simultaneous req0/req1 to the same index SHALL be serialized per REQ-017/018; no merging.

Reset
REQ-027 While reset=0: write_enable=0, write_index=0, write_data=0, counter=0, state NORMAL, force1=0, both ready=0, hazard_a=hazard_b=0.
REQ-028 Reset mid-operation SHALL discard any accepted-but-uncommitted write; write_enable SHALL drop to 0 asynchronously.
REQ-029 First transfer SHALL be possible on the first rising edge after reset returns to 1.

Verification
REQ-030 Single req0 write idx 5 data 0xDEADBEEF -> req0_ready=1 same cycle; next cycle write_enable=1, write_index=5, write_data=0xDEADBEEF; following cycle write_enable=0.
REQ-031 Both valid continuously, STARVE_LIMIT=3 -> grant order 0,0,0,1,0,0,0,1; force1=1 in the cycle of each req1 grant.
REQ-032 req0 write idx 0 data 0x1234 -> req0_ready=1, write_enable stays 0, hazard_a=0 with hazard_index_a=0.
REQ-033 req1 write idx 9, hazard_index_b=9 -> hazard_b=1 in grant cycle and commit cycle, 0 afterwards.
REQ-034 reset driven 0 between clock edges while write_enable=1 -> write_enable, counter, force1 clear immediately without a clock edge; no commit after release.
REQ-035 req1 alone back-to-back idx 1,2,3 -> write_enable=1 three consecutive cycles with indices 1,2,3, counter remains 0.

Source files
------------

// File: rtl/mips_cpu_wb_arbiter_if.sv
// Writeback bus between the two writeback requesters, the arbiter and the register-file write port.
// The arbiter takes the slave modport; whoever drives the requests takes the master modport.
interface mips_cpu_wb_arbiter_if;
  logic        req0_valid;
  logic [4:0]  req0_index;
  logic [31:0] req0_data;
  logic        req0_ready;

  logic        req1_valid;
  logic [4:0]  req1_index;
  logic [31:0] req1_data;
  logic        req1_ready;

  logic        write_enable;
  logic [4:0]  write_index;
  logic [31:0] write_data;

  logic [4:0]  hazard_index_a;
  logic [4:0]  hazard_index_b;
  logic        hazard_a;
  logic        hazard_b;

  logic        force1;

  modport slave (
    input  req0_valid, req0_index, req0_data,
    input  req1_valid, req1_index, req1_data,
    input  hazard_index_a, hazard_index_b,
    output req0_ready, req1_ready,
    output write_enable, write_index, write_data,
    output hazard_a, hazard_b, force1
  );

  modport master (
    output req0_valid, req0_index, req0_data,
    output req1_valid, req1_index, req1_data,
    output hazard_index_a, hazard_index_b,
    input  req0_ready, req1_ready,
    input  write_enable, write_index, write_data,
    input  hazard_a, hazard_b, force1
  );
endinterface

// File: rtl/mips_cpu_wb_arbiter.sv
// Merges the ALU (req0) and load (req1) writebacks onto one register-file write port.
// ALU normally wins; after STARVE_LIMIT ALU wins in a row over a waiting load, the load gets one turn.
module mips_cpu_wb_arbiter #(
  parameter int STARVE_LIMIT = 3
) (
  input logic                  clk,
  input logic                  reset,
  mips_cpu_wb_arbiter_if.slave bus
);

  typedef enum logic {NORMAL, FAIR} state_e;

  localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [4:0]  idx_q, idx_d;
  logic [31:0] data_q, data_d;

  logic        grant0, grant1, xfer;
  logic [4:0]  xfer_idx;
  logic [31:0] xfer_data;

  // Grants are gated by reset so nothing is accepted while the block is held in reset.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (reset) begin
      if (state_q == FAIR) begin
        grant1 = bus.req1_valid;
        grant0 = bus.req0_valid & ~bus.req1_valid;
      end else begin
        grant0 = bus.req0_valid;
        grant1 = bus.req1_valid & ~bus.req0_valid;
      end
    end
  end

  assign xfer      = grant0 | grant1;
  assign xfer_idx  = grant1 ? bus.req1_index : bus.req0_index;
  assign xfer_data = grant1 ? bus.req1_data  : bus.req0_data;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = 1'b0;
    idx_d   = idx_q;
    data_d  = data_q;

    if (grant1 || !bus.req1_valid) begin
      cnt_d = 3'd0;
    end else if (grant0 && cnt_q != LIMIT) begin
      cnt_d = cnt_q + 3'd1;
    end

    // Switching on the next count lets the load win on the very next cycle.
    case (state_q)
      NORMAL:  if (cnt_d == LIMIT) state_d = FAIR;
      FAIR:    if (grant1 || !bus.req1_valid) state_d = NORMAL;
      default: state_d = NORMAL;
    endcase

    if (xfer) begin
      we_d   = (xfer_idx != 5'd0);
      idx_d  = xfer_idx;
      data_d = xfer_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= NORMAL;
      cnt_q   <= 3'd0;
      we_q    <= 1'b0;
      idx_q   <= 5'd0;
      data_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
    end
  end

  assign bus.req0_ready   = grant0;
  assign bus.req1_ready   = grant1;
  assign bus.write_enable = we_q;
  assign bus.write_index  = idx_q;
  assign bus.write_data   = data_q;
  assign bus.force1       = (state_q == FAIR);

  // A register is hazardous from the cycle it is accepted until its commit cycle ends.
  assign bus.hazard_a = (bus.hazard_index_a != 5'd0) &&
                        ((we_q && bus.hazard_index_a == idx_q) ||
                         (xfer && bus.hazard_index_a == xfer_idx));
  assign bus.hazard_b = (bus.hazard_index_b != 5'd0) &&
                        ((we_q && bus.hazard_index_b == idx_q) ||
                         (xfer && bus.hazard_index_b == xfer_idx));

endmodule

// File: tb/tb_mips_cpu_wb_arbiter.sv
// Bench for the writeback arbiter: a directed vector table, hand-written starvation and
// asynchronous-reset sequences, then random traffic checked against a grant/commit model.
module tb_mips_cpu_wb_arbiter;

  localparam int LIMIT = 3;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  mips_cpu_wb_arbiter_if bus();

  mips_cpu_wb_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        v0;
    logic [4:0]  i0;
    logic [31:0] d0;
    logic        v1;
    logic [4:0]  i1;
    logic [31:0] d1;
    logic [4:0]  ha;
    logic [4:0]  hb;
    logic        r0;
    logic        r1;
    logic        f1;
    logic        hza;
    logic        hzb;
    logic        we;
    logic [4:0]  widx;
    logic [31:0] wdata;
  } vec_t;

  vec_t vecs[16];
  int   ord[8];

  // Random-phase model state: pending requests and expected register-file port.
  logic        p0v, p1v, g0, g1, hzaExp, hzbExp, mWe;
  logic [4:0]  p0i, p1i, gIdx, mIdx, ha, hb;
  logic [31:0] p0d, p1d, gData, mData;
  int          starve;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, want, $time);
    end
  endtask

  task automatic applyStimulus(input logic v0, input logic [4:0] i0, input logic [31:0] d0,
                               input logic v1, input logic [4:0] i1, input logic [31:0] d1,
                               input logic [4:0] hia, input logic [4:0] hib);
    @(negedge clk);
    bus.req0_valid     = v0;
    bus.req0_index     = i0;
    bus.req0_data      = d0;
    bus.req1_valid     = v1;
    bus.req1_index     = i1;
    bus.req1_data      = d1;
    bus.hazard_index_a = hia;
    bus.hazard_index_b = hib;
    #1;
  endtask

  task automatic doReset();
    reset              = 1'b0;
    bus.req0_valid     = 1'b1;
    bus.req0_index     = 5'd3;
    bus.req0_data      = 32'h33;
    bus.req1_valid     = 1'b1;
    bus.req1_index     = 5'd3;
    bus.req1_data      = 32'h44;
    bus.hazard_index_a = 5'd3;
    bus.hazard_index_b = 5'd3;
    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput("reset we",     bus.write_enable, 0);
    checkOutput("reset widx",   bus.write_index,  0);
    checkOutput("reset wdata",  bus.write_data,   0);
    checkOutput("reset ready0", bus.req0_ready,   0);
    checkOutput("reset ready1", bus.req1_ready,   0);
    checkOutput("reset force1", bus.force1,       0);
    checkOutput("reset hza",    bus.hazard_a,     0);
    checkOutput("reset hzb",    bus.hazard_b,     0);
    @(negedge clk);
    bus.req0_valid     = 1'b0;
    bus.req1_valid     = 1'b0;
    bus.hazard_index_a = 5'd0;
    bus.hazard_index_b = 5'd0;
    reset              = 1'b1;
  endtask

  function automatic logic [4:0] pickHazard(input logic [4:0] a, input logic [4:0] b, input logic [4:0] c);
    case ($urandom_range(0, 4))
      0:       return 5'd0;
      1:       return a;
      2:       return b;
      3:       return c;
      default: return 5'($urandom_range(0, 7));
    endcase
  endfunction

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset              = 1'b0;
    bus.req0_valid     = 1'b0;
    bus.req0_index     = 5'd0;
    bus.req0_data      = 32'd0;
    bus.req1_valid     = 1'b0;
    bus.req1_index     = 5'd0;
    bus.req1_data      = 32'd0;
    bus.hazard_index_a = 5'd0;
    bus.hazard_index_b = 5'd0;

    //             v0    i0     d0            v1    i1     d1          ha     hb     r0    r1    f1    hza   hzb   we    widx   wdata
    vecs[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  32'h0,     5'd0,  5'd5,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd5,  32'hDEADBEEF};
    vecs[1]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,     5'd0,  5'd5,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd5,  32'hDEADBEEF};
    vecs[2]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,     5'd0,  5'd5,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd5,  32'hDEADBEEF};
    vecs[3]  = '{1'b1, 5'd0,  32'h1234,     1'b0, 5'd0,  32'h0,     5'd0,  5'd5,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  32'h1234};
    vecs[4]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd9,  32'hA5A5,  5'd0,  5'd9,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd9,  32'hA5A5};
    vecs[5]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,     5'd0,  5'd9,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd9,  32'hA5A5};
    vecs[6]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,     5'd0,  5'd9,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd9,  32'hA5A5};
    vecs[7]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd1,  32'h11,    5'd2,  5'd3,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd1,  32'h11};
    vecs[8]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd2,  32'h22,    5'd2,  5'd3,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 5'd2,  32'h22};
    vecs[9]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd3,  32'h33,    5'd2,  5'd3,  1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 5'd3,  32'h33};
    vecs[10] = '{1'b1, 5'd7,  32'h70,       1'b1, 5'd8,  32'h80,    5'd0,  5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd7,  32'h70};
    vecs[11] = '{1'b1, 5'd10, 32'hA0,       1'b1, 5'd8,  32'h80,    5'd0,  5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd10, 32'hA0};
    vecs[12] = '{1'b1, 5'd11, 32'hB0,       1'b1, 5'd8,  32'h80,    5'd0,  5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd11, 32'hB0};
    vecs[13] = '{1'b1, 5'd12, 32'hC0,       1'b1, 5'd8,  32'h80,    5'd0,  5'd0,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 5'd8,  32'h80};
    vecs[14] = '{1'b1, 5'd12, 32'hC0,       1'b1, 5'd13, 32'hD0,    5'd0,  5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd12, 32'hC0};
    vecs[15] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,     5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd12, 32'hC0};

    ord = '{0, 0, 0, 1, 0, 0, 0, 1};

    doReset();

    $display("[TB] directed vector table");
    for (int k = 0; k < 16; k++) begin
      applyStimulus(vecs[k].v0, vecs[k].i0, vecs[k].d0, vecs[k].v1, vecs[k].i1, vecs[k].d1,
                    vecs[k].ha, vecs[k].hb);
      checkOutput($sformatf("vec%0d ready0", k), bus.req0_ready, vecs[k].r0);
      checkOutput($sformatf("vec%0d ready1", k), bus.req1_ready, vecs[k].r1);
      checkOutput($sformatf("vec%0d force1", k), bus.force1,     vecs[k].f1);
      checkOutput($sformatf("vec%0d hza", k),    bus.hazard_a,   vecs[k].hza);
      checkOutput($sformatf("vec%0d hzb", k),    bus.hazard_b,   vecs[k].hzb);
      @(posedge clk);
      #1;
      checkOutput($sformatf("vec%0d we", k),     bus.write_enable, vecs[k].we);
      checkOutput($sformatf("vec%0d widx", k),   bus.write_index,  vecs[k].widx);
      checkOutput($sformatf("vec%0d wdata", k),  bus.write_data,   vecs[k].wdata);
    end

    $display("[TB] starvation grant order");
    doReset();
    begin
      logic [4:0] n0, n1;
      n0 = 5'd20;
      n1 = 5'd30;
      for (int k = 0; k < 8; k++) begin
        applyStimulus(1'b1, n0, 32'h1000 + k, 1'b1, n1, 32'h2000 + k, 5'd0, 5'd0);
        checkOutput($sformatf("order%0d ready0", k), bus.req0_ready, ord[k] == 0);
        checkOutput($sformatf("order%0d ready1", k), bus.req1_ready, ord[k] == 1);
        checkOutput($sformatf("order%0d force1", k), bus.force1,     ord[k] == 1);
        @(posedge clk);
        #1;
        checkOutput($sformatf("order%0d widx", k), bus.write_index, (ord[k] == 0) ? n0 : n1);
        if (ord[k] == 0) n0 = n0 + 5'd1;
        else             n1 = n1 + 5'd1;
      end
    end

    $display("[TB] asynchronous reset mid-operation");
    doReset();
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 5'(16 + k), 32'h100 + k, 1'b1, 5'd17, 32'h200, 5'd0, 5'd0);
      @(posedge clk);
    end
    #1;
    checkOutput("armed force1", bus.force1,       1);
    checkOutput("armed we",     bus.write_enable, 1);
    checkOutput("armed widx",   bus.write_index,  18);
    bus.hazard_index_a = 5'd18;
    #2;
    reset = 1'b0;
    #1;
    checkOutput("async we",     bus.write_enable, 0);
    checkOutput("async widx",   bus.write_index,  0);
    checkOutput("async wdata",  bus.write_data,   0);
    checkOutput("async force1", bus.force1,       0);
    checkOutput("async ready0", bus.req0_ready,   0);
    checkOutput("async ready1", bus.req1_ready,   0);
    checkOutput("async hza",    bus.hazard_a,     0);
    @(posedge clk);
    #1;
    checkOutput("held we", bus.write_enable, 0);
    @(negedge clk);
    reset              = 1'b1;
    bus.hazard_index_a = 5'd0;
    bus.req0_valid     = 1'b1;
    bus.req0_index     = 5'd4;
    bus.req0_data      = 32'h44;
    bus.req1_valid     = 1'b1;
    bus.req1_index     = 5'd6;
    bus.req1_data      = 32'h66;
    #1;
    checkOutput("release ready0", bus.req0_ready, 1);
    checkOutput("release ready1", bus.req1_ready, 0);
    checkOutput("release force1", bus.force1,     0);
    @(posedge clk);
    #1;
    checkOutput("release we",    bus.write_enable, 1);
    checkOutput("release widx",  bus.write_index,  4);
    checkOutput("release wdata", bus.write_data,   32'h44);

    $display("[TB] random traffic against model");
    doReset();
    p0v = 1'b0; p1v = 1'b0;
    p0i = 5'd0; p1i = 5'd0;
    p0d = 32'd0; p1d = 32'd0;
    mWe = 1'b0; mIdx = 5'd0; mData = 32'd0;
    starve = 0;
    for (int c = 0; c < 400; c++) begin
      if (!p0v && $urandom_range(0, 9) < 6) begin
        p0v = 1'b1;
        p0i = 5'($urandom_range(0, 7));
        p0d = $urandom;
      end
      if (!p1v && $urandom_range(0, 9) < 5) begin
        p1v = 1'b1;
        p1i = 5'($urandom_range(0, 7));
        p1d = $urandom;
      end
      ha = pickHazard(p0i, p1i, mIdx);
      hb = pickHazard(p1i, mIdx, p0i);

      // Load wins when it is the only requester or the ALU has already starved it LIMIT times.
      g1    = p1v && (starve >= LIMIT || !p0v);
      g0    = p0v && !g1;
      gIdx  = g1 ? p1i : p0i;
      gData = g1 ? p1d : p0d;
      hzaExp = (ha != 5'd0) && ((mWe && ha == mIdx) || ((g0 || g1) && ha == gIdx));
      hzbExp = (hb != 5'd0) && ((mWe && hb == mIdx) || ((g0 || g1) && hb == gIdx));

      applyStimulus(p0v, p0i, p0d, p1v, p1i, p1d, ha, hb);
      checkOutput($sformatf("rand%0d ready0", c), bus.req0_ready, g0);
      checkOutput($sformatf("rand%0d ready1", c), bus.req1_ready, g1);
      checkOutput($sformatf("rand%0d force1", c), bus.force1,     starve >= LIMIT);
      checkOutput($sformatf("rand%0d hza", c),    bus.hazard_a,   hzaExp);
      checkOutput($sformatf("rand%0d hzb", c),    bus.hazard_b,   hzbExp);
      @(posedge clk);
      #1;
      if (g0 || g1) begin
        mWe   = (gIdx != 5'd0);
        mIdx  = gIdx;
        mData = gData;
      end else begin
        mWe = 1'b0;
      end
      if (g0 && p1v) starve = starve + 1;
      else           starve = 0;
      if (g0) p0v = 1'b0;
      if (g1) p1v = 1'b0;
      checkOutput($sformatf("rand%0d we", c),    bus.write_enable, mWe);
      checkOutput($sformatf("rand%0d widx", c),  bus.write_index,  mIdx);
      checkOutput($sformatf("rand%0d wdata", c), bus.write_data,   mData);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
